// File: rtl/shape_cnn_top.sv
// Tiny 3x3 shape classifier: 2x2 conv over four streamed windows, two FC layers, one-hot argmax.
// Optional macro SHAPE_CNN_RELU_EN clamps conv outputs and hidden activations at zero.
module shape_cnn_top #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                learn,
    input  logic                classify,
    input  logic [4*DATA_W-1:0] pixels,
    output logic [7:0]          result,
    output logic [ADDR_W-1:0]   KMEM_ADD1,
    output logic [ADDR_W-1:0]   KMEM_ADD2,
    output logic [ADDR_W-1:0]   WMEM_ADD1,
    output logic [ADDR_W-1:0]   WMEM_ADD2,
    output logic                KMEM_CSB1,
    output logic                KMEM_CSB2,
    output logic                WMEM_CSB1,
    output logic                WMEM_CSB2,
    output logic                KMEM_OEB1,
    output logic                KMEM_OEB2,
    output logic                WMEM_OEB1,
    output logic                WMEM_OEB2,
    output logic                KMEM_WEB1,
    output logic                KMEM_WEB2,
    output logic                WMEM_WEB1,
    output logic                WMEM_WEB2,
    input  logic [4*DATA_W-1:0] KR_DATA_I1,
    input  logic [4*DATA_W-1:0] KR_DATA_I2,
    input  logic [4*DATA_W-1:0] W1_DATA_I1,
    input  logic [4*DATA_W-1:0] W1_DATA_I2,
    input  logic [4*DATA_W-1:0] W2_DATA_I1,
    input  logic [4*DATA_W-1:0] W2_DATA_I2
);

    localparam int WordW = 4 * DATA_W;
    localparam int SumW  = 2 * DATA_W + 2;
    localparam logic signed [SumW-1:0] SatHi = SumW'(2 ** (DATA_W - 1) - 1);
    localparam logic signed [SumW-1:0] SatLo = SumW'(-(2 ** (DATA_W - 1)));

    typedef enum logic [2:0] {StIdle, StLd0, StLd1, StLd2, StConv, StFc1, StFc2} state_e;

    state_e state_q, state_d;

    // Vectors hold element j at byte [3-j], matching the weight-word byte order.
    logic [WordW-1:0]  kernel_q;
    logic [WordW-1:0]  w1_q [4];
    logic [WordW-1:0]  w2_q [4];
    logic [WordW-1:0]  f_q;
    logic [WordW-1:0]  hid_q;
    logic [1:0]        cnt_q;
    logic [7:0]        result_q;

    logic [DATA_W-1:0]      f_new;
    logic [WordW-1:0]       hid_new;
    logic signed [SumW-1:0] score [4];
    logic [1:0]             best;
    logic                   sample_en;
    logic [1:0]             samp_idx;
    logic                   mem_en;
    logic [ADDR_W-1:0]      add1, add2;
    logic                   unused_kr2;

    function automatic logic signed [SumW-1:0] dot4(input logic [WordW-1:0] a,
                                                    input logic [WordW-1:0] b);
        logic signed [SumW-1:0]     acc;
        logic signed [DATA_W-1:0]   x, y;
        logic signed [2*DATA_W-1:0] p;
        acc = '0;
        for (int k = 0; k < 4; k++) begin
            x   = a[DATA_W*k +: DATA_W];
            y   = b[DATA_W*k +: DATA_W];
            p   = x * y;
            acc = acc + SumW'(p);
        end
        return acc;
    endfunction

    function automatic logic [DATA_W-1:0] sat(input logic signed [SumW-1:0] v);
        if (v > SatHi) begin
            return SatHi[DATA_W-1:0];
        end else if (v < SatLo) begin
            return SatLo[DATA_W-1:0];
        end
        return v[DATA_W-1:0];
    endfunction

    function automatic logic [DATA_W-1:0] act(input logic [DATA_W-1:0] v);
`ifdef SHAPE_CNN_RELU_EN
        return v[DATA_W-1] ? '0 : v;
`else
        return v;
`endif
    endfunction

    assign unused_kr2 = ^KR_DATA_I2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (learn) begin
                    state_d = StLd0;
                end else if (classify) begin
                    state_d = StConv;
                end
            end
            StLd0:  state_d = StLd1;
            StLd1:  state_d = StLd2;
            StLd2:  state_d = StIdle;
            StConv: begin
                if (!classify) begin
                    state_d = StIdle;
                end else if (cnt_q == 2'd3) begin
                    state_d = StFc1;
                end
            end
            StFc1:  state_d = StFc2;
            StFc2:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        mem_en = 1'b0;
        add1   = '0;
        add2   = '0;
        unique case (state_q)
            StLd0: begin
                mem_en = 1'b1;
                add1   = ADDR_W'(0);
                add2   = ADDR_W'(1);
            end
            StLd1: begin
                mem_en = 1'b1;
                add1   = ADDR_W'(2);
                add2   = ADDR_W'(3);
            end
            default: ;
        endcase
    end

    assign KMEM_ADD1 = add1;
    assign KMEM_ADD2 = add2;
    assign WMEM_ADD1 = add1;
    assign WMEM_ADD2 = add2;
    assign KMEM_CSB1 = ~mem_en;
    assign KMEM_CSB2 = ~mem_en;
    assign WMEM_CSB1 = ~mem_en;
    assign WMEM_CSB2 = ~mem_en;
    assign KMEM_OEB1 = ~mem_en;
    assign KMEM_OEB2 = ~mem_en;
    assign WMEM_OEB1 = ~mem_en;
    assign WMEM_OEB2 = ~mem_en;
    assign KMEM_WEB1 = 1'b1;
    assign KMEM_WEB2 = 1'b1;
    assign WMEM_WEB1 = 1'b1;
    assign WMEM_WEB2 = 1'b1;
    assign result    = result_q;

    assign sample_en = ((state_q == StIdle) && !learn && classify) ||
                       ((state_q == StConv) && classify);
    assign samp_idx  = (state_q == StIdle) ? 2'd0 : cnt_q;
    assign f_new     = act(sat(dot4(kernel_q, pixels)));

    always_comb begin
        hid_new = '0;
        for (int h = 0; h < 4; h++) begin
            hid_new[DATA_W*(3-h) +: DATA_W] = act(sat(dot4(w1_q[h], f_q)));
        end
        for (int c = 0; c < 4; c++) begin
            score[c] = dot4(w2_q[c], hid_q);
        end
        // Strict compare keeps the lowest class index on ties.
        best = 2'd0;
        for (int c = 1; c < 4; c++) begin
            if (score[c] > score[best]) begin
                best = 2'(c);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            kernel_q <= '0;
            f_q      <= '0;
            hid_q    <= '0;
            cnt_q    <= 2'd0;
            result_q <= 8'h00;
            for (int i = 0; i < 4; i++) begin
                w1_q[i] <= '0;
                w2_q[i] <= '0;
            end
        end else begin
            if (sample_en) begin
                f_q[DATA_W*(3 - 32'(samp_idx)) +: DATA_W] <= f_new;
                cnt_q <= samp_idx + 2'd1;
            end
            // SRAM data trails the address by one cycle.
            if (state_q == StLd1) begin
                kernel_q <= KR_DATA_I1;
                w1_q[0]  <= W1_DATA_I1;
                w1_q[1]  <= W1_DATA_I2;
                w2_q[0]  <= W2_DATA_I1;
                w2_q[1]  <= W2_DATA_I2;
            end
            if (state_q == StLd2) begin
                w1_q[2] <= W1_DATA_I1;
                w1_q[3] <= W1_DATA_I2;
                w2_q[2] <= W2_DATA_I1;
                w2_q[3] <= W2_DATA_I2;
            end
            if (state_q == StFc1) begin
                hid_q <= hid_new;
            end
            if (state_q == StFc2) begin
                result_q <= {4'b0000, 4'b0001 << best};
            end
        end
    end

endmodule

// File: tb/tb_shape_cnn_top.sv
// Scoreboard bench for shape_cnn_top: stimulus queues expected result/pin values with a due cycle,
// a negedge monitor pops and compares them.
module tb_shape_cnn_top;

    localparam int ADDR_W = 5;

    logic        clk;
    logic        rst;
    logic        learn;
    logic        classify;
    logic [31:0] pixels;
    logic [7:0]  result;
    logic [ADDR_W-1:0] KMEM_ADD1, KMEM_ADD2, WMEM_ADD1, WMEM_ADD2;
    logic KMEM_CSB1, KMEM_CSB2, WMEM_CSB1, WMEM_CSB2;
    logic KMEM_OEB1, KMEM_OEB2, WMEM_OEB1, WMEM_OEB2;
    logic KMEM_WEB1, KMEM_WEB2, WMEM_WEB1, WMEM_WEB2;
    logic [31:0] KR_DATA_I1, KR_DATA_I2, W1_DATA_I1, W1_DATA_I2, W2_DATA_I1, W2_DATA_I2;

    shape_cnn_top #(.ADDR_W(ADDR_W), .DATA_W(8)) dut (
        .clk(clk), .rst(rst), .learn(learn), .classify(classify), .pixels(pixels),
        .result(result),
        .KMEM_ADD1(KMEM_ADD1), .KMEM_ADD2(KMEM_ADD2), .WMEM_ADD1(WMEM_ADD1), .WMEM_ADD2(WMEM_ADD2),
        .KMEM_CSB1(KMEM_CSB1), .KMEM_CSB2(KMEM_CSB2), .WMEM_CSB1(WMEM_CSB1), .WMEM_CSB2(WMEM_CSB2),
        .KMEM_OEB1(KMEM_OEB1), .KMEM_OEB2(KMEM_OEB2), .WMEM_OEB1(WMEM_OEB1), .WMEM_OEB2(WMEM_OEB2),
        .KMEM_WEB1(KMEM_WEB1), .KMEM_WEB2(KMEM_WEB2), .WMEM_WEB1(WMEM_WEB1), .WMEM_WEB2(WMEM_WEB2),
        .KR_DATA_I1(KR_DATA_I1), .KR_DATA_I2(KR_DATA_I2),
        .W1_DATA_I1(W1_DATA_I1), .W1_DATA_I2(W1_DATA_I2),
        .W2_DATA_I1(W2_DATA_I1), .W2_DATA_I2(W2_DATA_I2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous read-only SRAM models, one cycle of read latency.
    logic [31:0] kmem [32];
    logic [31:0] w1mem [32];
    logic [31:0] w2mem [32];
    assign KR_DATA_I2 = 32'ha5a5a5a5;

    always @(posedge clk) begin
        if (!KMEM_CSB1 && !KMEM_OEB1) KR_DATA_I1 <= kmem[KMEM_ADD1];
        if (!WMEM_CSB1 && !WMEM_OEB1) begin
            W1_DATA_I1 <= w1mem[WMEM_ADD1];
            W2_DATA_I1 <= w2mem[WMEM_ADD1];
        end
        if (!WMEM_CSB2 && !WMEM_OEB2) begin
            W1_DATA_I2 <= w1mem[WMEM_ADD2];
            W2_DATA_I2 <= w2mem[WMEM_ADD2];
        end
    end

    typedef struct {
        int          due;
        bit          is_pins;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    logic [7:0] last_result = 8'h00;

    function automatic logic [31:0] pins_now();
        return {KMEM_ADD1, KMEM_ADD2, WMEM_ADD1, WMEM_ADD2,
                KMEM_CSB1, KMEM_CSB2, WMEM_CSB1, WMEM_CSB2,
                KMEM_OEB1, KMEM_OEB2, WMEM_OEB1, WMEM_OEB2,
                KMEM_WEB1, KMEM_WEB2, WMEM_WEB1, WMEM_WEB2};
    endfunction

    function automatic logic [31:0] exp_pins(input int a1, input int a2, input bit en);
        logic [4:0] x1, x2;
        x1 = 5'(a1);
        x2 = 5'(a2);
        return {x1, x2, x1, x2, {4{~en}}, {4{~en}}, 4'hf};
    endfunction

    // Monitor: compare every entry whose due cycle has arrived.
    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] got;
        while (sbq.size() > 0 && sbq[0].due <= cyc) begin
            e   = sbq.pop_front();
            got = e.is_pins ? pins_now() : {24'h0, result};
            checks++;
            if (e.due != cyc || got !== e.exp) begin
                errors++;
                $display("FAIL %s cycle %0d (due %0d): got %h expected %h",
                         e.name, cyc, e.due, got, e.exp);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_result(input int due, input logic [7:0] v, input string n);
        exp_t e;
        e.due = due; e.is_pins = 1'b0; e.exp = {24'h0, v}; e.name = n;
        sbq.push_back(e);
    endtask

    task automatic push_pins(input int due, input int a1, input int a2, input bit en,
                             input string n);
        exp_t e;
        e.due = due; e.is_pins = 1'b1; e.exp = exp_pins(a1, a2, en); e.name = n;
        sbq.push_back(e);
    endtask

    task automatic do_load(input string n);
        int k;
        k = cyc;
        learn = 1'b1;
        push_pins(k + 1, 0, 1, 1'b1, {n, "_beat0"});
        push_pins(k + 2, 2, 3, 1'b1, {n, "_beat1"});
        push_pins(k + 3, 0, 0, 1'b0, {n, "_ld2"});
        tick();
        learn = 1'b0;
        repeat (3) tick();
    endtask

    task automatic do_frame(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2,
                            input logic [31:0] w3, input logic [7:0] exp, input string n);
        int k;
        k = cyc;
        classify = 1'b1;
        pixels   = w0;
        push_result(k + 5, last_result, {n, "_hold"});
        push_result(k + 6, exp, n);
        tick();
        pixels = w1;
        tick();
        pixels = w2;
        tick();
        pixels = w3;
        tick();
        classify = 1'b0;
        pixels   = 32'h0;
        tick();
        tick();
        last_result = exp;
    endtask

    task automatic do_abort();
        int k;
        k = cyc;
        classify = 1'b1;
        pixels   = 32'h0;
        tick();
        tick();
        classify = 1'b0;
        push_result(k + 3, last_result, "abort_k3");
        push_result(k + 5, last_result, "abort_k5");
        push_result(k + 7, last_result, "abort_k7");
        repeat (5) tick();
    endtask

    task automatic do_reset_mid_load();
        int k;
        k = cyc;
        learn = 1'b1;
        push_pins(k + 1, 0, 1, 1'b1, "rml_beat0");
        tick();
        learn = 1'b0;
        tick();
        rst = 1'b0;
        push_pins(k + 2, 0, 0, 1'b0, "rml_pins");
        push_result(k + 2, 8'h00, "rml_result");
        @(negedge clk);
        #1;
        rst = 1'b1;
        last_result = 8'h00;
        tick();
    endtask

    initial begin
        rst      = 1'b0;
        learn    = 1'b0;
        classify = 1'b0;
        pixels   = 32'h0;
        for (int i = 0; i < 32; i++) begin
            kmem[i]  = 32'h0;
            w1mem[i] = 32'h0;
            w2mem[i] = 32'h0;
        end

        repeat (2) tick();
        push_pins(cyc, 0, 0, 1'b0, "reset_pins");
        push_result(cyc, 8'h00, "reset_result");

        checks++;
        if (result !== 8'h00) begin
            errors++;
            $display("FAIL reset_direct_result: got %h expected 00", result);
        end
        checks++;
        if (KMEM_CSB1 !== 1'b1 || WMEM_CSB1 !== 1'b1) begin
            errors++;
            $display("FAIL reset_direct_csb: got %b/%b expected 1/1", KMEM_CSB1, WMEM_CSB1);
        end
        checks++;
        if (KMEM_WEB1 !== 1'b1) begin
            errors++;
            $display("FAIL reset_direct_web: got %b expected 1", KMEM_WEB1);
        end

        @(negedge clk);
        #1;
        rst = 1'b1;
        tick();

        // X-shape weights
        kmem[0]  = 32'h01ffff01;
        w1mem[0] = 32'h01ffff01; w1mem[1] = 32'hff0101ff;
        w1mem[2] = 32'hffffffff; w1mem[3] = 32'hff0101ff;
        w2mem[0] = 32'hff0101ff; w2mem[1] = 32'h01ffff01;
        w2mem[2] = 32'h01ffff01; w2mem[3] = 32'hffffffff;
        do_load("load_x");

        do_frame(32'h01ffff01, 32'hff0101ff, 32'hff0101ff, 32'h01ffff01, 8'h02, "frame_x");
        do_frame(32'hff0101ff, 32'h01ffff01, 32'h01ffff01, 32'hff0101ff, 8'h01, "frame_inv");
        do_frame(32'h01ffff01, 32'hff0101ff, 32'hff0101ff, 32'h01ffff01, 8'h02, "frame_x2");
        do_abort();
        do_frame(32'h0, 32'h0, 32'h0, 32'h0, 8'h01, "frame_zero_tie");

        // Saturation weights: f and hid both clip at 127, c1 = 2*hid0 beats c0 = hid1.
        kmem[0]  = 32'h7f7f7f7f;
        w1mem[0] = 32'h01010101; w1mem[1] = 32'h64000000;
        w1mem[2] = 32'h00000000; w1mem[3] = 32'h00000000;
        w2mem[0] = 32'h00010000; w2mem[1] = 32'h02000000;
        w2mem[2] = 32'h00000000; w2mem[3] = 32'h00000000;
        do_load("load_sat");
        do_frame(32'h7f7f7f7f, 32'h7f7f7f7f, 32'h7f7f7f7f, 32'h7f7f7f7f, 8'h02, "frame_sat");

        do_reset_mid_load();
        do_frame(32'h7f7f7f7f, 32'h7f7f7f7f, 32'h7f7f7f7f, 32'h7f7f7f7f, 8'h01, "frame_cleared");

        checks++;
        if (result !== last_result) begin
            errors++;
            $display("FAIL final_direct_result: got %h expected %h", result, last_result);
        end

        for (int i = 0; i < 10 && sbq.size() > 0; i++) tick();
        while (sbq.size() > 0) begin
            exp_t e;
            e = sbq.pop_front();
            checks++;
            errors++;
            $display("FAIL %s never checked: got none expected %h", e.name, e.exp);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
